// File: rtl/max_reduce_pkg.sv
// Shared types and constants for the streaming unsigned max-reduction block.
// The block and its comparator both import this package.
package max_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned IDX_WIDTH_DEF = 16;
  localparam int unsigned CNT_MAX       = (32'd1 << IDX_WIDTH_DEF) - 32'd1;

  // All-ones count limit for an arbitrary index width.
  function automatic logic [31:0] cnt_limit(input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return lim;
  endfunction

endpackage

// File: rtl/gt_uint_nbit.sv
// Combinational unsigned strict greater-than comparator (y = a > b).
// IMPL_TYPE 0 uses the native operator; any other value uses an MSB-first scan.
module gt_uint_nbit #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             y
);

  generate
    if (IMPL_TYPE == 0) begin : g_native
      assign y = (a > b);
    end else begin : g_scan
      logic gt_s;
      logic decided_s;

      // The first differing bit from the top decides the result.
      always_comb begin
        gt_s      = 1'b0;
        decided_s = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          gt_s      = decided_s ? gt_s : (a[i] & ~b[i]);
          decided_s = decided_s | (a[i] ^ b[i]);
        end
      end

      assign y = gt_s;
    end
  endgenerate

endmodule

// File: rtl/max_reduce_uint32.sv
// Streaming running-maximum reducer: one packet in over valid/ready, one
// {max, first index, count, truncated} result out over valid/ready.
module max_reduce_uint32
  import max_reduce_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_max,
  output logic [IDX_WIDTH-1:0] out_idx,
  output logic [IDX_WIDTH-1:0] out_count,
  output logic                 out_trunc
);

  localparam logic [31:0]          LIM_32  = cnt_limit(IDX_WIDTH);
  localparam logic [IDX_WIDTH-1:0] CNT_LIM = LIM_32[IDX_WIDTH-1:0];
  localparam logic [IDX_WIDTH-1:0] CNT_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 trunc_q, trunc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept_s;
  logic                 upd_s;
  logic [IDX_WIDTH-1:0] cnt_inc_s;

  gt_uint_nbit #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .a (in_data),
    .b (max_q),
    .y (upd_s)
  );

  assign accept_s  = in_valid & in_ready_q;
  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state, running max/index capture and result flags.
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          max_d   = in_data;
          idx_d   = {IDX_WIDTH{1'b0}};
          cnt_d   = CNT_ONE;
          trunc_d = 1'b0;
          if (in_last) begin
            state_d = DONE;
          end else if (CNT_ONE == CNT_LIM) begin
            state_d = DONE;
            trunc_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCUM: begin
        if (accept_s) begin
          // Strictly greater keeps the earliest index on ties.
          if (upd_s) begin
            max_d = in_data;
            idx_d = cnt_q;
          end else begin
            max_d = max_q;
            idx_d = idx_q;
          end
          cnt_d = cnt_inc_s;
          if (in_last) begin
            state_d = DONE;
          end else if (cnt_inc_s == CNT_LIM) begin
            state_d = DONE;
            trunc_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          trunc_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state, never from out_ready directly.
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      max_q       <= {WIDTH{1'b0}};
      idx_q       <= {IDX_WIDTH{1'b0}};
      cnt_q       <= {IDX_WIDTH{1'b0}};
      trunc_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      trunc_q     <= trunc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_count = cnt_q;
  assign out_trunc = trunc_q;

endmodule

// File: tb/tb_max_reduce_uint32.sv
// Directed self-checking bench for max_reduce_uint32 with IDX_WIDTH=4 so the
// truncation boundary (count 15) is reachable with short packets.
module tb_max_reduce_uint32;

  localparam int W  = 32;
  localparam int IW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] out_count;
  logic          out_trunc;

  int checks_n;
  int fails_n;

  max_reduce_uint32 #(
    .WIDTH     (W),
    .IMPL_TYPE (0),
    .IDX_WIDTH (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] m, input logic [31:0] i,
                              input logic [31:0] c, input logic [31:0] t);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_max"},   out_max, m);
    check_eq({tag, "_idx"},   32'(out_idx), i);
    check_eq({tag, "_count"}, 32'(out_count), c);
    check_eq({tag, "_trunc"}, 32'(out_trunc), t);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    checks_n  = 0;
    fails_n   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_max",   out_max, 32'd0);
    check_eq("rst_idx",   32'(out_idx), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    check_eq("rst_trunc", 32'(out_trunc), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);

    // Single-word packet.
    send(32'h0000_0005, 1'b1);
    check_result("single", 32'd5, 32'd0, 32'd1, 32'd0);
    handshake("single");

    // Four-word packet, out_ready held high: in_ready low exactly one cycle.
    out_ready = 1'b1;
    send(32'd3, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'd7, 1'b0);
    send(32'h8000_0000, 1'b1);
    out_ready = 1'b1;
    check_result("pkt4", 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd0);
    tick();
    out_ready = 1'b0;
    check_eq("pkt4_ready_back", 32'(in_ready), 32'd1);
    check_eq("pkt4_valid_gone", 32'(out_valid), 32'd0);

    // Ties keep the first index.
    send(32'd9, 1'b0);
    send(32'd2, 1'b0);
    send(32'd9, 1'b0);
    send(32'd9, 1'b1);
    check_result("ties", 32'd9, 32'd0, 32'd4, 32'd0);
    handshake("ties");

    // Input gap plus 5 cycles of output backpressure with a waiting next packet.
    send(32'd1, 1'b0);
    tick();
    send(32'd4, 1'b1);
    check_result("bp", 32'd4, 32'd1, 32'd2, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'd99;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_result($sformatf("bp_hold%0d", k), 32'd4, 32'd1, 32'd2, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_hs_valid", 32'(out_valid), 32'd0);
    check_eq("bp_hs_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("bp_next", 32'd99, 32'd0, 32'd1, 32'd0);
    handshake("bp_next");

    // Truncation at count 15 (IDX_WIDTH=4); word 15 starts a new packet.
    for (int k = 0; k < 15; k++) begin
      send(32'(k), 1'b0);
    end
    check_result("trunc", 32'd14, 32'd14, 32'd15, 32'd1);
    in_valid  = 1'b1;
    in_data   = 32'd15;
    in_last   = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("trunc_hs_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("trunc_next", 32'd15, 32'd0, 32'd1, 32'd0);
    handshake("trunc_next");

    // Reset mid-packet discards the partial result.
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("midrst_valid2", 32'(out_valid), 32'd0);
    check_eq("midrst_ready2", 32'(in_ready), 32'd1);
    send(32'd0, 1'b0);
    send(32'd0, 1'b1);
    check_result("after_rst", 32'd0, 32'd0, 32'd2, 32'd0);
    handshake("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule

// File: doc/max_reduce_uint32.md
# max_reduce_uint32

Streaming running-maximum controller for unsigned integers. It accepts a packet of WIDTH-bit words over a valid/ready input, one word per cycle, and reduces the packet to its maximum and that word's position. It sequences a single shared unsigned greater-than comparator across the packet, then presents one result per packet on a valid/ready output. It sits between a PIM operand stream and any consumer of reduction results.

## Interface
- WIDTH, 32, data word width in bits.
- IMPL_TYPE, 0, implementation selector passed unchanged to the comparator.
- IDX_WIDTH, 16, width of the element index and count fields.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  in_data and in_last are valid.
- in_ready  output  1  block accepts an input word this cycle.
- in_data  input  WIDTH  unsigned input word.
- in_last  input  1  marks the final word of the packet.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out_max  output  WIDTH  maximum value in the packet.
- out_idx  output  IDX_WIDTH  0-based position of the first occurrence of out_max.
- out_count  output  IDX_WIDTH  number of words in the packet, saturating at 2^IDX_WIDTH-1.
- out_trunc  output  1  packet was force-terminated at the maximum count.

## Operation
- There is one clock; reset is synchronous and active-high.
- The state machine has three states: IDLE, ACCUM and DONE.
- IDLE: waiting for the first word. in_ready=1. On accept:
  - max_reg<=in_data, idx_reg<=0, cnt<=1.
  - Go to DONE if in_last is set, otherwise go to ACCUM.
- ACCUM: in_ready=1. On accept, the comparator evaluates in_data > max_reg, strictly greater.
  - If true: max_reg<=in_data, idx_reg<=cnt.
  - cnt<=cnt+1 in all cases.
  - Go to DONE if in_last is set or cnt+1 reaches 2^IDX_WIDTH-1. In the second case without in_last, set trunc.
- ACCUM with in_valid=0: state holds and nothing changes. Gaps inside a packet are legal.
- DONE: in_ready=0 and out_valid=1. Outputs are driven from max_reg, idx_reg, cnt and trunc. The outputs must stay stable until out_valid && out_ready. On that handshake, go to IDLE and clear trunc.
- Ties keep the earlier index, because the compare is strictly greater.
- After truncation, the remaining words of that packet are treated as a new packet. The upstream source is responsible for avoiding this.
- Reset values: state=IDLE, in_ready=0 while rst=1, out_valid=0, out_max=0, out_idx=0, out_count=0, out_trunc=0.
- Reset asserted mid-packet or in DONE discards the partial or pending result with no output.
- All arithmetic is unsigned. cnt never exceeds 2^IDX_WIDTH-1.

## Timing
- in_ready is a function of state only, with no combinational path from out_ready. It is high from the first cycle after rst deasserts.
- A word is accepted on the edge where in_valid && in_ready.
- Result latency: out_valid rises on the edge that accepts the last word. It is visible the cycle after the last word is presented.
- Minimum period for an N-word packet is N+1 cycles: N accept cycles plus at least one DONE cycle. in_ready reasserts the cycle after the output handshake.
- The compare and max update complete in one cycle. The comparator is combinational between max_reg and in_data.
- in_last is sampled only on accept.

## Structure
- Package max_reduce_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the default IDX_WIDTH;
  - the localparam CNT_MAX = 2^IDX_WIDTH-1.
- One sub-module instance, gt_uint_nbit, with WIDTH and IMPL_TYPE passed through.
  - A = in_data, B = max_reg, Y = update enable.
  - The max mux and index capture are local to this block.

## Test plan
- Single word: 0x0000_0005 with in_last=1 in the first accept cycle -> the next cycle gives out_valid=1, out_max=5, out_idx=0, out_count=1, out_trunc=0.
- Packet {3, 0xFFFF_FFFF, 7, 0x8000_0000}, last on the 4th word, out_ready held high -> out_max=0xFFFF_FFFF, out_idx=1, out_count=4, and in_ready is low for exactly one cycle.
- Ties: {9, 2, 9, 9} -> out_max=9, out_idx=0.
- Backpressure and gaps: in_valid toggles 1,0,1 across packet {1,4}, and out_ready is held low for 5 cycles -> out_max=4, out_idx=1. Outputs stay stable and in_ready stays 0 for all 5 cycles. The next packet is accepted only after the handshake.
- Truncation with IDX_WIDTH=4: 16 words of value k (k=0..15) and no last -> the result appears after the 15th word with out_count=15, out_trunc=1, out_max=14, out_idx=14. Word 15 then starts a new packet.
- Reset: rst asserted for one cycle after 2 words of a packet -> no output. The following packet {0, 0} gives out_max=0, out_idx=0, out_count=2.
